// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM family.
package ram_pkg;

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

    localparam int unsigned COLL_READ_FIRST  = 0;
    localparam int unsigned COLL_WRITE_FIRST = 1;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address once, taking over the RAM write port while busy.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_W-1:0]     clr_addr_o,
    output logic [DATA_W/8-1:0]   clr_be_o,
    output logic [DATA_W-1:0]     clr_data_o
);

    localparam clr_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;

    clr_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps to zero on the last address, ready for the next clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR_RUN;
                    cnt_d   = '0;
                end
            end
            CLR_RUN: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign busy_o     = (state_q == CLR_RUN);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = cnt_q;
    assign clr_be_o   = '1;
    assign clr_data_o = '0;

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read latency,
// configurable same-address collision behaviour and a built-in clear engine.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned COLL_MODE      = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int unsigned BE_W  = be_width(DATA_W);
    localparam int unsigned DEPTH = depth_of(ADDR_W);

    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("ram_dp_param: DATA_W must be a multiple of 8");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("ram_dp_param: RD_LAT must be 1 or 2");
    end

    logic                 clr_we;
    logic [ADDR_W-1:0]    clr_addr;
    logic [BE_W-1:0]      clr_be;
    logic [DATA_W-1:0]    clr_data;

    ram_clear_fsm #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_be_o   (clr_be),
        .clr_data_o (clr_data)
    );

    logic [DATA_W-1:0]    mem_q [DEPTH];

    // A clear request in IDLE swallows any user access in the same cycle.
    logic                 acc_ok, wr_go, rd_go;
    assign acc_ok = ~busy & ~clr_req;
    assign wr_go  = acc_ok & wr_en;
    assign rd_go  = acc_ok & rd_en;

    logic                 mw_en;
    logic [ADDR_W-1:0]    mw_addr;
    logic [BE_W-1:0]      mw_be;
    logic [DATA_W-1:0]    mw_data;
    logic [DATA_W-1:0]    merged;

    assign mw_en   = clr_we | wr_go;
    assign mw_addr = clr_we ? clr_addr : wr_addr;
    assign mw_be   = clr_we ? clr_be   : wr_be;
    assign mw_data = clr_we ? clr_data : wr_data;

    always_comb begin
        merged = mem_q[mw_addr];
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (mw_be[i]) begin
                merged[8*i +: 8] = mw_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mw_en) begin
            mem_q[mw_addr] <= merged;
        end
    end

    logic [DATA_W-1:0]    rd_word;
    assign rd_word = ((COLL_MODE == COLL_WRITE_FIRST) && wr_go && (wr_addr == rd_addr))
                     ? merged : mem_q[rd_addr];

    logic [DATA_W-1:0]    rd1_data_q;
    logic                 rd1_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_data_q <= '0;
            rd1_vld_q  <= 1'b0;
        end else begin
            rd1_vld_q <= rd_go;
            if (rd_go) begin
                rd1_data_q <= rd_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd2_data_q;
        logic              rd2_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd2_data_q <= '0;
                rd2_vld_q  <= 1'b0;
            end else begin
                rd2_vld_q <= rd1_vld_q;
                if (rd1_vld_q) begin
                    rd2_data_q <= rd1_data_q;
                end
            end
        end

        assign rd_data  = rd2_data_q;
        assign rd_valid = rd2_vld_q;
    end else begin : g_lat1
        assign rd_data  = rd1_data_q;
        assign rd_valid = rd1_vld_q;
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench: two RAM instances (read-first/latency 1, write-first/latency 2)
// share one stimulus stream and are checked against an array-based reference.
module tb_ram_dp_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clr_req = 1'b0;

    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          a_rd_valid, b_rd_valid;
    logic          a_busy, b_busy;

    always #5 clk = ~clk;

    ram_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COLL_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .clr_req(clr_req), .busy(a_busy)
    );

    ram_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .COLL_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .clr_req(clr_req), .busy(b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] m_mem [DEPTH];
    int          left = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (a_rd_valid) begin
                if (qa.size() == 0) chk("A spurious rd_valid", a_rd_valid, 0);
                else begin
                    e = qa.pop_front();
                    chk("A rd_data", a_rd_data, e.data);
                    chk("A latency", cyc, e.due);
                end
                last_a = a_rd_data;
            end else chk("A rd_data hold", a_rd_data, last_a);
            if (b_rd_valid) begin
                if (qb.size() == 0) chk("B spurious rd_valid", b_rd_valid, 0);
                else begin
                    e = qb.pop_front();
                    chk("B rd_data", b_rd_data, e.data);
                    chk("B latency", cyc, e.due);
                end
                last_b = b_rd_data;
            end else chk("B rd_data hold", b_rd_data, last_b);
        end
    end

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] wbe, input logic re, input logic [3:0] ra,
                        input logic cr);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra; clr_req = cr;
        chk("A busy", a_busy, left > 0);
        chk("B busy", b_busy, left > 0);
        if (left > 0) begin
            left--;
        end else if (cr) begin
            left = DEPTH;
            zero_model();
        end else begin
            if (re) qa.push_back('{data: m_mem[ra], due: cyc + 1});
            if (we) for (int i = 0; i < 4; i++)
                if (wbe[i]) m_mem[wa][8*i +: 8] = wd[8*i +: 8];
            if (re) qb.push_back('{data: m_mem[ra], due: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 0; rd_en = 0; clr_req = 0;
        #1;
        chk("A rd_data in reset", a_rd_data, 0);
        chk("A rd_valid in reset", a_rd_valid, 0);
        chk("B rd_data in reset", b_rd_data, 0);
        chk("B rd_valid in reset", b_rd_valid, 0);
        qa.delete();
        qb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        left = DEPTH;
        zero_model();
    endtask

    initial begin
        #2;
        do_reset();
        idle(DEPTH + 1);

        for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 0, 1, 4'(a), 0);

        step(1, 3, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
        step(1, 3, 32'h11223344, 4'b0101, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 0);

        step(1, 7, 32'h0000005A, 4'b0001, 1, 7, 0);
        idle(2);

        for (int a = 0; a < 4; a++) step(1, 4'(a), 32'h10 + 32'(a), 4'hF, 0, 0, 0);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 1, 4'(a), 0);

        // Clear request swallows the same-cycle write; mid-clear request must not extend busy.
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 2, 32'h000000FF, 4'hF, 0, 0, 1);
        for (int k = 0; k < DEPTH; k++) step(1, 4'(k), 32'hDEADBEEF, 4'hF, 1, 4'(k), k == 7);
        idle(1);
        for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 0, 1, 4'(a), 0);

        step(1, 5, 32'h12345678, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(5);
        do_reset();
        idle(DEPTH + 1);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa, ra;
            wa = ($urandom % 3 == 0) ? 4'($urandom % 4) : 4'($urandom);
            ra = ($urandom % 3 == 0) ? 4'($urandom % 4) : 4'($urandom);
            step(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra,
                 ($urandom % 64) == 0);
        end

        idle(4);
        chk("A queue drained", qa.size(), 0);
        chk("B queue drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
Parametrised simple-dual-port synchronous RAM. It is the next-generation storage primitive for the design and replaces fixed 16x8 single-port instances. It provides one write port and one read port usable in the same cycle, per-byte write enables, and selectable read latency with a valid strobe. A built-in clear engine zeroes the array after reset and on request.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
COLL_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset release

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data; holds its last value between reads
rd_valid  out  1  one-cycle strobe: rd_data carries a new read result
clr_req  in  1  single-cycle pulse; starts a full-array clear
busy  out  1  clear engine active; requests are ignored while high

Behaviour:
- Reset (asynchronous, rst_n=0): rd_data=0, rd_valid=0, read pipeline flushed, clear address counter=0.
  - busy=1 if CLEAR_ON_RESET=1, otherwise 0.
  - Array contents are not reset; only the clear engine zeroes them.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt; clr_cnt increments each cycle; exits to IDLE after address DEPTH-1 is written, i.e. DEPTH cycles total. busy=1.
  - IDLE: normal operation. busy=0.
- Transitions:
  - Reset release goes to CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).
  - IDLE and clr_req=1 goes to CLEAR with clr_cnt=0 on the next edge. Any wr_en/rd_en in that same cycle are ignored.
  - clr_req while in CLEAR is ignored; there is no restart.
  - Reset during CLEAR aborts the clear; the clear restarts from 0 if CLEAR_ON_RESET=1.
- Write: in IDLE with wr_en=1, bytes with wr_be[i]=1 update at wr_addr on the edge. Bytes with wr_be[i]=0 keep their contents. wr_be=0 is a legal no-op.
- Read: in IDLE with rd_en=1, mem[rd_addr] appears on rd_data together with rd_valid=1:
  - RD_LAT=1: one cycle after the request edge.
  - RD_LAT=2: two cycles after, through an extra output register.
- Reads are fully pipelined; back-to-back rd_en gives back-to-back rd_valid.
- Reads already in the pipeline when CLEAR begins still complete and return pre-clear data. New rd_en in CLEAR produces no rd_valid.
- Simultaneous write and read to different addresses: both are serviced in the same cycle.
- Same-address collision:
  - COLL_MODE=0: the read returns the pre-write word.
  - COLL_MODE=1: the read returns the merged word (enabled bytes from wr_data, the rest old).
- Addresses wrap naturally at DEPTH. There is no out-of-range case because DEPTH is 2**ADDR_W.
- Elaboration must fail for DATA_W%8 != 0 or for RD_LAT not in {1,2}.

Decomposition:
- Shared package ram_pkg holds:
  - typedef clr_state_t {CLR_IDLE, CLR_RUN};
  - localparam functions for BE_W = DATA_W/8 and DEPTH.
  - COLL_READ_FIRST = 0 and COLL_WRITE_FIRST = 1 constants.
- One sub-module, ram_clear_fsm: owns the state register, clr_cnt and busy, and drives an internal write-port override (address, all-ones be, zero data) into the top level.
- The array, byte merge, collision mux and read pipeline stay in ram_dp_param.

Test Plan:
- Reset clear: CLEAR_ON_RESET=1, DEPTH=16; release rst_n → busy=1 for exactly 16 cycles. Then reading all addresses returns 0x00 with rd_valid one cycle after each rd_en (RD_LAT=1).
- Byte enables: DATA_W=32; write 0xAABBCCDD be=4'b1111, then 0x11223344 be=4'b0101 to addr 3 → read returns 0xAA22CC44.
- Collision: write 0x5A to addr 7 (old 0x00) and read addr 7 in the same cycle → rd_data=0x00 with COLL_MODE=0, 0x5A with COLL_MODE=1.
- Latency/streaming: RD_LAT=2; rd_en on 4 consecutive cycles to addrs 0..3 pre-loaded 0x10..0x13 → rd_valid high for 4 consecutive cycles starting 2 cycles after the first request, data 0x10..0x13 in order.
- Clear request: in IDLE with data loaded, pulse clr_req together with wr_en (addr 2, 0xFF) → write is dropped, busy high for DEPTH cycles, a second clr_req mid-clear does not extend busy, all addresses read 0 afterwards.
- Reset mid-clear: assert rst_n=0 at cycle 5 of CLEAR → rd_data=0 and rd_valid=0 immediately. After release, busy lasts the full DEPTH cycles again.
